// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared sequencer state encoding and counter width helper.
package perceptron_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MAC,
        ST_ACT,
        ST_UPDATE,
        ST_OUT
    } state_e;

    // Width of a counter covering 0..n-1, never narrower than one bit.
    function automatic int cw(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/perceptron_step_cnt.sv
// perceptron_step_cnt: wrapping step counter used for feature index and neuron select.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear to 0 (wins over inc)
//   inc        : advance by one, wrapping from N-1 to 0
//   cnt        : current count
//   last       : cnt == N-1
module perceptron_step_cnt
    import perceptron_pkg::*;
#(
    parameter int N = 4,
    localparam int W = cw(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         last
);

    logic [W-1:0] cnt_q;

    assign cnt  = cnt_q;
    assign last = cnt_q == W'(N - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (clr)
            cnt_q <= '0;
        else if (inc)
            cnt_q <= last ? '0 : cnt_q + W'(1);
    end

endmodule

// File: rtl/perceptron_seq_ctrl.sv
// perceptron_seq_ctrl: multi-neuron clear/MAC/activate/update sequencer for the perceptron datapath.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   val_i, train_i, rdy_o   : sample input handshake, mode captured on accept
//   val_o, rdy_i            : result output handshake
//   err_i                   : datapath output/target mismatch, sampled in ACT
//   acc_clr, acc_en, act_en : accumulator clear, multiply-accumulate, activation strobes
//   wt_we                   : weight write strobe for w[neuron][idx]
//   idx, neuron             : current feature index and neuron
//   busy                    : a sample is being processed
module perceptron_seq_ctrl
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS  = 4,
    parameter int N_NEURONS = 2,
    localparam int IW = cw(N_INPUTS),
    localparam int NW = cw(N_NEURONS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          val_i,
    input  logic          train_i,
    output logic          rdy_o,
    output logic          val_o,
    input  logic          rdy_i,
    input  logic          err_i,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          act_en,
    output logic          wt_we,
    output logic [IW-1:0] idx,
    output logic [NW-1:0] neuron,
    output logic          busy
);

    state_e state_q;
    logic   init_q;
    logic   train_q;
    logic   err_q;
    logic   idx_last;
    logic   nrn_last;
    logic   accept;
    logic   upd_go;
    logic   nxt_nrn;
    logic   go_clear;

    assign accept   = val_i && rdy_o;
    assign upd_go   = state_q == ST_ACT && train_q && err_i;
    assign nxt_nrn  = (state_q == ST_ACT && !upd_go) || (state_q == ST_UPDATE && idx_last);
    assign go_clear = nxt_nrn && !nrn_last;

    // idx stops at N_INPUTS-1 instead of wrapping so it holds its last value in ACT/OUT.
    perceptron_step_cnt #(.N(N_INPUTS)) u_idx (
        .clk  (clk),
        .reset(reset),
        .clr  (accept || go_clear || upd_go),
        .inc  ((state_q == ST_MAC || state_q == ST_UPDATE) && !idx_last),
        .cnt  (idx),
        .last (idx_last)
    );

    perceptron_step_cnt #(.N(N_NEURONS)) u_nrn (
        .clk  (clk),
        .reset(reset),
        .clr  (accept),
        .inc  (go_clear),
        .cnt  (neuron),
        .last (nrn_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            init_q  <= 1'b0;
            train_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            init_q <= 1'b1;
            case (state_q)
                ST_IDLE: if (accept) begin
                    train_q <= train_i;
                    state_q <= ST_CLEAR;
                end
                ST_CLEAR:  state_q <= ST_MAC;
                ST_MAC:    if (idx_last) state_q <= ST_ACT;
                ST_ACT: begin
                    err_q   <= err_i;
                    state_q <= upd_go ? ST_UPDATE : nrn_last ? ST_OUT : ST_CLEAR;
                end
                ST_UPDATE: if (idx_last) state_q <= nrn_last ? ST_OUT : ST_CLEAR;
                ST_OUT:    if (rdy_i) state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // init_q keeps rdy_o low until the first edge after reset release.
    assign rdy_o   = init_q && state_q == ST_IDLE;
    assign val_o   = state_q == ST_OUT;
    assign acc_clr = state_q == ST_CLEAR;
    assign acc_en  = state_q == ST_MAC;
    assign act_en  = state_q == ST_ACT;
    // UPDATE is only entered for an erring neuron, so err_q qualifies the write.
    assign wt_we   = state_q == ST_UPDATE && err_q;
    assign busy    = state_q != ST_IDLE && state_q != ST_OUT;

endmodule

// File: doc/perceptron_seq_ctrl.md
# perceptron_seq_ctrl

Parametrised control path for the perceptron network, replacing the single-step controller with a multi-neuron, multi-input sequencer. Accepts one sample per val/rdy handshake, walks every neuron through clear → multiply-accumulate → activate, optionally runs a weight-update pass (training mode), then presents the result on a val/rdy output port. Drives only datapath strobes and indices; all arithmetic stays in the perceptron datapath.

## Interface

- `N_INPUTS`, 4: features per sample, ≥1.
- `N_NEURONS`, 2: neurons evaluated per sample, ≥1.
- `IW`, derived `max(1,$clog2(N_INPUTS))`: index width.
- `NW`, derived `max(1,$clog2(N_NEURONS))`: neuron-select width.

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `val_i` in 1: sample valid from upstream.
- `train_i` in 1: mode; sampled with the input handshake, 1 = training.
- `rdy_o` out 1: ready for a new sample.
- `val_o` out 1: result valid to downstream.
- `rdy_i` in 1: downstream ready.
- `err_i` in 1: datapath mismatch flag (output ≠ target), valid during `act_en`.
- `acc_clr` out 1: clear accumulator.
- `acc_en` out 1: accumulate `x[idx]*w[neuron][idx]`.
- `act_en` out 1: apply activation, latch output bit for `neuron`.
- `wt_we` out 1: write updated weight `w[neuron][idx]`.
- `idx` out IW: current feature index.
- `neuron` out NW: current neuron.
- `busy` out 1: sample in flight (not IDLE, not OUT).

## Operation

- States: IDLE, CLEAR, MAC, ACT, UPDATE, OUT.
- IDLE: `rdy_o`=1. On `val_i && rdy_o`: latch `train_i` into `train_q`, set `neuron`=0, go CLEAR.
- CLEAR: `acc_clr`=1 for one cycle, `idx`=0, go MAC.
- MAC: `acc_en`=1 for N_INPUTS cycles, `idx` counts 0..N_INPUTS-1; after the cycle with `idx`=N_INPUTS-1 go ACT.
- ACT: `act_en`=1 for one cycle; latch `err_q` = `err_i`. If `train_q && err_i`: `idx`=0, go UPDATE. Otherwise go to the next neuron.
- UPDATE: `wt_we`=1 for N_INPUTS cycles, `idx` 0..N_INPUTS-1, then go to the next neuron.
- Next neuron: if `neuron`=N_NEURONS-1 go OUT, else `neuron`+1, go CLEAR.
- OUT: `val_o`=1 and held until `rdy_i`; on `val_o && rdy_i` go IDLE.
- `err_i` is ignored outside ACT, and in inference mode.
- All strobes are mutually exclusive and are 0 in IDLE and OUT. `idx` and `neuron` hold their last value when unused.
- Counters wrap exactly at N−1. N_INPUTS=1 gives a 1-cycle MAC/UPDATE. N_NEURONS=1 makes `neuron` a constant 0.

## Timing

- Reset values: state IDLE; `rdy_o`=0; all other outputs 0; `idx`=0; `neuron`=0; `train_q`=0; `err_q`=0.
- `rdy_o` goes to 1 on the first rising edge after `reset` deasserts, using a registered init flag.
- All outputs are decoded from registered state and counters. No combinational path from `val_i`/`rdy_i` to any output.
- Inference latency: `val_o` rises N_NEURONS×(N_INPUTS+2) cycles after the accepting edge.
- Training latency: add N_INPUTS cycles for each neuron with `err_i`=1 in ACT.
- `rdy_o` is 1 only in IDLE. The earliest next accept is one cycle after the output handshake.
- `val_o` is stable while `rdy_i`=0. `val_o` is never withdrawn without a handshake.
- `reset` asserted mid-sample: immediate asynchronous return to IDLE; all strobes drop to 0 the same cycle; the sample is discarded and no `val_o` is produced.
- `val_i` asserted outside IDLE is ignored (not accepted). `train_i` changes after acceptance have no effect.

## Structure

- Shared package `perceptron_pkg`: state enum (`ST_IDLE`..`ST_OUT`), and width helper function `cw(n)` = `max(1,$clog2(n))`.
- Sub-module `perceptron_step_cnt`: parametrised wrapping counter with inputs `clr`, `inc`, and outputs `cnt` and `last`.
  - Instantiated twice: once for `idx` (MAC/UPDATE), once for `neuron`.
- FSM, init flag and `train_q`/`err_q` live in `perceptron_seq_ctrl`.

## Test plan

- Reset then idle (N_INPUTS=4, N_NEURONS=2), `reset` held 3 cycles → all outputs 0 during reset; `rdy_o`=1 one edge after release.
- Inference, `train_i`=0, `rdy_i`=1 → per neuron: 1 `acc_clr`, 4 `acc_en` with `idx` 0,1,2,3, 1 `act_en`, for neuron 0 then 1. `val_o` rises 12 cycles after accept; `wt_we` never asserts.
- Training, `err_i`=1 for neuron 0 only → neuron 0 gets 4 `wt_we` cycles with `idx` 0..3; neuron 1 gets none; `val_o` at 16 cycles.
- Backpressure, `rdy_i`=0 for 5 cycles in OUT → `val_o` held 5+1 cycles, `rdy_o`=0 throughout; next `val_i` is accepted one cycle after the handshake.
- `reset` pulsed during MAC with `idx`=2 → strobes 0 immediately; state IDLE; no `val_o`; the following sample completes normally in 12 cycles.
- Corner N_INPUTS=1, N_NEURONS=1, training with `err_i`=1 → CLEAR, MAC, ACT, UPDATE one cycle each; `val_o` at cycle 4.
